// File: rtl/kb_pkg.sv
// Shared keyboard types and constants used by the scanner, the event encoder and key consumers.
package kb_pkg;

  localparam int unsigned KEY_W  = 16;
  localparam int unsigned CODE_W = 4;

  localparam logic [KEY_W-1:0] KEY_IDLE = 16'hFFFF;

  typedef logic [CODE_W-1:0] key_code_t;

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic key_code_t lowest_index(input logic [KEY_W-1:0] v);
    key_code_t idx;
    idx = '0;
    for (int i = int'(KEY_W) - 1; i >= 0; i--) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO with registered head, empty and full; push and pop may coincide at any occupancy.
module key_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             do_push, do_pop;

  always_comb begin
    do_pop     = pop & ~empty;
    do_push    = push & (~full | do_pop);
    rd_ptr_nxt = do_pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
    wr_ptr_nxt = do_push ? wr_ptr + PTR_W'(1) : wr_ptr;
    count_nxt  = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
    // The next head is the incoming word when it lands in the slot about to become the head.
    head_nxt = (do_push && (wr_ptr == rd_ptr_nxt)) ? wdata : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
      rdata  <= head_nxt;
      empty  <= (count_nxt == '0);
      full   <= (count_nxt == CNT_W'(DEPTH));
      if (do_push) mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/key_event_encoder.sv
// Debounces the raw active-low key vector, turns new presses into key codes and queues them
// for a valid/ready consumer.
module key_event_encoder
  import kb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key,
  input  logic             key_ready,
  input  logic             ovf_clr,
  output key_code_t        key_code,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_stable,
  output logic             any_pressed,
  output logic             overflow
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEY_W-1:0] s1, s2;
  logic [KEY_W-1:0] cand, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [KEY_W-1:0] stable_nxt;
  logic [KEY_W-1:0] pending, pending_nxt;
  logic [KEY_W-1:0] new_press, served;
  logic             overflow_nxt;
  logic             ovf_set;
  logic             fifo_push, fifo_pop;
  logic             fifo_empty, fifo_full;
  key_code_t        push_code;

  // Two-flop synchroniser for the asynchronous scanner vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= KEY_IDLE;
      s2 <= KEY_IDLE;
    end else begin
      s1 <= key;
      s2 <= s1;
    end
  end

  // Whole-vector debounce, press detection and the one-bit-per-cycle encoder.
  always_comb begin
    cand_nxt   = cand;
    cnt_nxt    = cnt;
    stable_nxt = key_stable;
    if (s2 != cand) begin
      cand_nxt = s2;
      cnt_nxt  = '0;
    end else begin
      if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
      if (cnt == CNT_MAX) stable_nxt = cand;
    end

    new_press = key_stable & ~stable_nxt;
    served    = pending & (~pending + KEY_W'(1));
    push_code = lowest_index(pending);

    fifo_pop  = key_valid & key_ready;
    fifo_push = (|pending) & (~fifo_full | fifo_pop);
    ovf_set   = (|pending) & fifo_full & ~fifo_pop;

    // New presses are OR-ed in last so a re-press of the bit being served is kept.
    pending_nxt  = (pending & ~served) | new_press;
    overflow_nxt = ovf_set | (overflow & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand        <= KEY_IDLE;
      cnt         <= '0;
      key_stable  <= KEY_IDLE;
      any_pressed <= 1'b0;
      pending     <= '0;
      overflow    <= 1'b0;
    end else begin
      cand        <= cand_nxt;
      cnt         <= cnt_nxt;
      key_stable  <= stable_nxt;
      any_pressed <= ~&stable_nxt;
      pending     <= pending_nxt;
      overflow    <= overflow_nxt;
    end
  end

  key_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (push_code),
    .pop   (fifo_pop),
    .rdata (key_code),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign key_valid = ~fifo_empty;

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder with DEBOUNCE_CYCLES=4 and FIFO_DEPTH=4.
module tb_key_event_encoder;
  import kb_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [KEY_W-1:0] key;
  logic             key_ready;
  logic             ovf_clr;
  key_code_t        key_code;
  logic             key_valid;
  logic [KEY_W-1:0] key_stable;
  logic             any_pressed;
  logic             overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] events [$];

  key_event_encoder #(
    .DEBOUNCE_CYCLES (4),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .key_ready   (key_ready),
    .ovf_clr     (ovf_clr),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_stable  (key_stable),
    .any_pressed (any_pressed),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every handshake; inputs only move 1 time unit after a rising edge.
  always @(negedge clk) begin
    if (rst_n && key_valid && key_ready) events.push_back(key_code);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected codes packed 4 bits each, first event in the low nibble.
  task automatic check_events(input string tag, input int n, input logic [19:0] exp);
    logic [3:0] got;
    check({tag, "_count"}, 32'(events.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < events.size()) ? events[i] : 4'hx;
      check($sformatf("%s_ev%0d", tag, i), 32'(got), 32'(exp[4*i +: 4]));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    key       = 16'hFFFF;
    key_ready = 1'b0;
    ovf_clr   = 1'b0;
    tick(2);
    check("rst_stable", 32'(key_stable), 32'hFFFF);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_any", 32'(any_pressed), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    tick(3);

    // Single press of key 5: stable on the 7th edge after the drive (6 after the sampling edge).
    key_ready = 1'b1;
    events.delete();
    key = 16'hFFDF;
    tick(6);
    check("t1_stable_early", 32'(key_stable), 32'hFFFF);
    tick(1);
    check("t1_stable", 32'(key_stable), 32'hFFDF);
    check("t1_any", 32'(any_pressed), 32'h1);
    check("t1_valid_early", 32'(key_valid), 32'h0);
    tick(1);
    check("t1_valid", 32'(key_valid), 32'h1);
    check("t1_code", 32'(key_code), 32'h5);
    tick(1);
    check("t1_valid_pop", 32'(key_valid), 32'h0);
    tick(11);
    key = 16'hFFFF;
    tick(12);
    check("t1_rel_stable", 32'(key_stable), 32'hFFFF);
    check("t1_rel_any", 32'(any_pressed), 32'h0);
    check("t1_rel_valid", 32'(key_valid), 32'h0);
    check_events("t1", 1, 20'h5);

    // Bounce on key 3 every 2 cycles never settles.
    events.delete();
    for (int i = 0; i < 10; i++) begin
      key[3] = i[0];
      tick(1);
      check("t2_stable", 32'(key_stable), 32'hFFFF);
      tick(1);
      check("t2_stable", 32'(key_stable), 32'hFFFF);
    end
    key = 16'hFFFF;
    tick(10);
    check("t2_stable_end", 32'(key_stable), 32'hFFFF);
    check("t2_valid", 32'(key_valid), 32'h0);
    check_events("t2", 0, 20'h0);

    // Keys 9, 2 and 14 together come out in ascending order on consecutive cycles.
    events.delete();
    key = 16'hBDFB;
    tick(7);
    check("t3_stable", 32'(key_stable), 32'hBDFB);
    tick(1);
    check("t3_code0", {31'd0, key_valid} << 4 | 32'(key_code), 32'h12);
    tick(1);
    check("t3_code1", {31'd0, key_valid} << 4 | 32'(key_code), 32'h19);
    tick(1);
    check("t3_code2", {31'd0, key_valid} << 4 | 32'(key_code), 32'h1E);
    tick(1);
    check("t3_valid_end", 32'(key_valid), 32'h0);
    check_events("t3", 3, 20'hE92);
    key = 16'hFFFF;
    tick(10);

    // Five keys with no consumer: four queued, key 13 dropped.
    key_ready = 1'b0;
    events.delete();
    key = 16'hDB6D;
    tick(14);
    check("t4_ovf", 32'(overflow), 32'h1);
    check("t4_valid", 32'(key_valid), 32'h1);
    check("t4_head", 32'(key_code), 32'h1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("t4_ovf_clr", 32'(overflow), 32'h0);
    key_ready = 1'b1;
    tick(4);
    check("t4_drained", 32'(key_valid), 32'h0);
    check_events("t4", 4, 20'hA741);
    key_ready = 1'b0;
    key = 16'hFFFF;
    tick(10);
    check("t4_rel_valid", 32'(key_valid), 32'h0);

    // Full FIFO with a pop in the cycle key 12 is served.
    events.delete();
    key = 16'hEEB6;
    tick(11);
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
    check("t5_ovf", 32'(overflow), 32'h0);
    check("t5_valid", 32'(key_valid), 32'h1);
    check("t5_head", 32'(key_code), 32'h3);
    key_ready = 1'b1;
    tick(4);
    check("t5_drained", 32'(key_valid), 32'h0);
    tick(1);
    check("t5_still_empty", 32'(key_valid), 32'h0);
    check_events("t5", 5, 20'hC8630);
    key_ready = 1'b0;
    key = 16'hFFFF;
    tick(10);

    // Asynchronous reset with two events queued and key 5 mid-debounce.
    key = 16'hF7FB;
    tick(10);
    check("t6_valid_pre", 32'(key_valid), 32'h1);
    key = 16'hF7DB;
    tick(3);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(key_valid), 32'h0);
    check("t6_stable", 32'(key_stable), 32'hFFFF);
    check("t6_ovf", 32'(overflow), 32'h0);
    check("t6_any", 32'(any_pressed), 32'h0);
    key = 16'hFFFF;
    tick(2);
    rst_n = 1'b1;
    events.delete();
    key_ready = 1'b1;
    tick(15);
    check("t6_valid_post", 32'(key_valid), 32'h0);
    check_events("t6", 0, 20'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
